// File: rtl/fpu_issue_queue_if.sv
// Decode-to-FPU issue queue bus: decode request, FPU issue handshake and writeback.
// The master side is the surrounding pipeline; the slave side is fpu_issue_queue.
interface fpu_issue_queue_if;
   logic       dec_fpu_valid;
   logic [8:0] dec_fpu_pkt;
   logic [4:0] dec_fpu_rs1;
   logic [4:0] dec_fpu_rs2;
   logic [4:0] dec_fpu_rs3;
   logic [4:0] dec_fpu_rd;
   logic       dec_fpu_src_fp32;
   logic       dec_fpu_dst_fp32;
   logic       dec_fpu_stall;
   logic       fpu_valid;
   logic       fpu_ready;
   logic [3:0] fpu_op;
   logic       fpu_op_mod;
   logic [2:0] fpu_rnd_mode;
   logic [4:0] fpu_rs1;
   logic [4:0] fpu_rs2;
   logic [4:0] fpu_rs3;
   logic [4:0] fpu_rd;
   logic       fpu_src_fp32;
   logic       fpu_dst_fp32;
   logic       fpu_wb_valid;
   logic [4:0] fpu_wb_rd;
   logic       flush;
   logic       fpu_q_empty;

   modport master (
      output dec_fpu_valid, dec_fpu_pkt, dec_fpu_rs1, dec_fpu_rs2, dec_fpu_rs3, dec_fpu_rd,
             dec_fpu_src_fp32, dec_fpu_dst_fp32, fpu_ready, fpu_wb_valid, fpu_wb_rd, flush,
      input  dec_fpu_stall, fpu_valid, fpu_op, fpu_op_mod, fpu_rnd_mode, fpu_rs1, fpu_rs2,
             fpu_rs3, fpu_rd, fpu_src_fp32, fpu_dst_fp32, fpu_q_empty
   );

   modport slave (
      input  dec_fpu_valid, dec_fpu_pkt, dec_fpu_rs1, dec_fpu_rs2, dec_fpu_rs3, dec_fpu_rd,
             dec_fpu_src_fp32, dec_fpu_dst_fp32, fpu_ready, fpu_wb_valid, fpu_wb_rd, flush,
      output dec_fpu_stall, fpu_valid, fpu_op, fpu_op_mod, fpu_rnd_mode, fpu_rs1, fpu_rs2,
             fpu_rs3, fpu_rd, fpu_src_fp32, fpu_dst_fp32, fpu_q_empty
   );
endinterface

// File: rtl/fpu_issue_queue.sv
// In-order FP issue queue with RAW/WAW register scoreboard.
// Optional zero-latency empty-queue bypass enabled by defining FPU_ISSUE_BYPASS_EN.
module fpu_issue_queue_chk #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input logic             clk,
   input logic             rst_l,
   input logic             set_valid,
   input logic [4:0]       set_rd,
   input logic             clr_valid,
   input logic [4:0]       clr_rd,
   input logic [CNT_W-1:0] count
);
   // WAW is blocked at enqueue, so an issue and a writeback never target the same register.
   a_set_clr_collision: assert property (@(posedge clk) disable iff (!rst_l)
      !(set_valid && clr_valid && (set_rd == clr_rd)));

   a_count_bound: assert property (@(posedge clk) disable iff (!rst_l)
      count <= CNT_W'(DEPTH));
endmodule

module fpu_issue_queue #(
   parameter int DEPTH = 4
) (
   input logic               clk,
   input logic               rst_l,
   fpu_issue_queue_if.slave  q
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [3:0] op;
      logic       op_mod;
      logic [2:0] rnd_mode;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rs3;
      logic [4:0] rd;
      logic       src_fp32;
      logic       dst_fp32;
   } entry_t;

   entry_t           mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [31:0]      issued_busy_r;

   entry_t      dec_entry_s;
   entry_t      head_s;
   entry_t      out_entry_s;
   logic [31:0] busy_s;
   logic [31:0] busy_nxt_s;
   logic [31:0] set_mask_s;
   logic [31:0] clr_mask_s;
   logic [4:0]  set_rd_s;
   logic        set_valid_s;
   logic        empty_s;
   logic        full_s;
   logic        hazard_s;
   logic        stall_s;
   logic        enq_s;
   logic        deq_s;
   logic        bypass_s;
   logic        wr_en_s;
   logic        unused_pkt_valid_s;

   assign unused_pkt_valid_s = q.dec_fpu_pkt[8];

   assign dec_entry_s = '{op:       q.dec_fpu_pkt[4:1],
                          op_mod:   q.dec_fpu_pkt[0],
                          rnd_mode: q.dec_fpu_pkt[7:5],
                          rs1:      q.dec_fpu_rs1,
                          rs2:      q.dec_fpu_rs2,
                          rs3:      q.dec_fpu_rs3,
                          rd:       q.dec_fpu_rd,
                          src_fp32: q.dec_fpu_src_fp32,
                          dst_fp32: q.dec_fpu_dst_fp32};

   assign head_s = mem_r[rd_ptr_r];

   // Scoreboard: in-flight destinations plus destinations of every live queued entry.
   always_comb begin
      busy_s = issued_busy_r;
      for (int i = 0; i < DEPTH; i++) begin
         busy_s[mem_r[rd_ptr_r + PTR_W'(i)].rd] =
            busy_s[mem_r[rd_ptr_r + PTR_W'(i)].rd] | (CNT_W'(i) < count_r);
      end
   end

   assign empty_s  = (count_r == {CNT_W{1'b0}});
   assign full_s   = (count_r == CNT_W'(DEPTH));
   assign hazard_s = busy_s[q.dec_fpu_rs1] | busy_s[q.dec_fpu_rs2] |
                     busy_s[q.dec_fpu_rs3] | busy_s[q.dec_fpu_rd];
   assign stall_s  = q.dec_fpu_valid & (full_s | hazard_s | q.flush);
   assign enq_s    = q.dec_fpu_valid & ~stall_s;
   assign deq_s    = ~empty_s & q.fpu_ready & ~q.flush;

`ifdef FPU_ISSUE_BYPASS_EN
   assign bypass_s    = enq_s & empty_s & q.fpu_ready;
   assign q.fpu_valid = ~empty_s | bypass_s;
   assign out_entry_s = bypass_s ? dec_entry_s : head_s;
`else
   assign bypass_s    = 1'b0;
   assign q.fpu_valid = ~empty_s;
   assign out_entry_s = head_s;
`endif

   assign wr_en_s     = enq_s & ~bypass_s;
   assign set_valid_s = deq_s | bypass_s;
   assign set_rd_s    = bypass_s ? dec_entry_s.rd : head_s.rd;
   // Issue-set is applied after writeback-clear so a collision leaves the bit set.
   assign set_mask_s  = set_valid_s ? (32'h0000_0001 << set_rd_s) : 32'h0000_0000;
   assign clr_mask_s  = q.fpu_wb_valid ? (32'h0000_0001 << q.fpu_wb_rd) : 32'h0000_0000;
   assign busy_nxt_s  = (issued_busy_r & ~clr_mask_s) | set_mask_s;

   assign q.dec_fpu_stall = stall_s;
   assign q.fpu_op        = out_entry_s.op;
   assign q.fpu_op_mod    = out_entry_s.op_mod;
   assign q.fpu_rnd_mode  = out_entry_s.rnd_mode;
   assign q.fpu_rs1       = out_entry_s.rs1;
   assign q.fpu_rs2       = out_entry_s.rs2;
   assign q.fpu_rs3       = out_entry_s.rs3;
   assign q.fpu_rd        = out_entry_s.rd;
   assign q.fpu_src_fp32  = out_entry_s.src_fp32;
   assign q.fpu_dst_fp32  = out_entry_s.dst_fp32;
   assign q.fpu_q_empty   = empty_s & (issued_busy_r == 32'h0000_0000);

   // Queue storage, pointers, occupancy and in-flight scoreboard.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r      <= {PTR_W{1'b0}};
         rd_ptr_r      <= {PTR_W{1'b0}};
         count_r       <= {CNT_W{1'b0}};
         issued_busy_r <= 32'h0000_0000;
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= dec_entry_s;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (q.flush) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {CNT_W{1'b0}};
         end else begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(deq_s);
            count_r  <= count_r + CNT_W'(wr_en_s) - CNT_W'(deq_s);
         end
         issued_busy_r <= busy_nxt_s;
      end
   end

   fpu_issue_queue_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
      .clk       (clk),
      .rst_l     (rst_l),
      .set_valid (set_valid_s),
      .set_rd    (set_rd_s),
      .clr_valid (q.fpu_wb_valid),
      .clr_rd    (q.fpu_wb_rd),
      .count     (count_r)
   );
endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench for fpu_issue_queue: fill, full+deq, RAW, wrap, flush, bypass, async reset.
module tb_fpu_issue_queue;
   logic clk;
   logic rst_l;
   int   errors;
   int   checks;

   fpu_issue_queue_if bus ();

   fpu_issue_queue #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .q     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [2:0] rnd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rs3, input logic [4:0] rd);
      bus.dec_fpu_valid    = 1'b1;
      bus.dec_fpu_pkt      = {1'b1, rnd, op, 1'b0};
      bus.dec_fpu_rs1      = rs1;
      bus.dec_fpu_rs2      = rs2;
      bus.dec_fpu_rs3      = rs3;
      bus.dec_fpu_rd       = rd;
      bus.dec_fpu_src_fp32 = 1'b0;
      bus.dec_fpu_dst_fp32 = 1'b1;
   endtask

   task automatic wb(input logic [4:0] rd);
      bus.fpu_wb_valid = 1'b1;
      bus.fpu_wb_rd    = rd;
      tick();
      bus.fpu_wb_valid = 1'b0;
      bus.fpu_wb_rd    = 5'd0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_l  = 1'b0;
      bus.dec_fpu_valid    = 1'b0;
      bus.dec_fpu_pkt      = 9'd0;
      bus.dec_fpu_rs1      = 5'd0;
      bus.dec_fpu_rs2      = 5'd0;
      bus.dec_fpu_rs3      = 5'd0;
      bus.dec_fpu_rd       = 5'd0;
      bus.dec_fpu_src_fp32 = 1'b0;
      bus.dec_fpu_dst_fp32 = 1'b0;
      bus.fpu_ready        = 1'b0;
      bus.fpu_wb_valid     = 1'b0;
      bus.fpu_wb_rd        = 5'd0;
      bus.flush            = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_stall", 32'(bus.dec_fpu_stall), 32'd0);
      chk("rst_valid", 32'(bus.fpu_valid), 32'd0);
      chk("rst_op", 32'(bus.fpu_op), 32'd0);
      chk("rst_rd", 32'(bus.fpu_rd), 32'd0);
      chk("rst_empty", 32'(bus.fpu_q_empty), 32'd1);
      rst_l = 1'b1;
      tick();

      // Fill: four independent ops with FPU not ready
      for (int i = 1; i <= 4; i++) begin
         send(4'(i), 3'd0, 5'd20, 5'd21, 5'd22, 5'(i));
         settle();
         chk("fill_stall", 32'(bus.dec_fpu_stall), 32'd0);
         tick();
      end
      send(4'd5, 3'd0, 5'd20, 5'd21, 5'd22, 5'd10);
      settle();
      chk("full_stall", 32'(bus.dec_fpu_stall), 32'd1);
      chk("full_valid", 32'(bus.fpu_valid), 32'd1);
      chk("full_head_rd", 32'(bus.fpu_rd), 32'd1);

      // Full + deq: op stalled this cycle, accepted next
      bus.fpu_ready = 1'b1;
      settle();
      chk("fulldeq_stall", 32'(bus.dec_fpu_stall), 32'd1);
      tick();
      chk("fulldeq_next_stall", 32'(bus.dec_fpu_stall), 32'd0);
      chk("fulldeq_head_rd", 32'(bus.fpu_rd), 32'd2);
      tick();
      bus.dec_fpu_valid = 1'b0;
      settle();
      chk("drain_rd0", 32'(bus.fpu_rd), 32'd3);
      tick();
      chk("drain_rd1", 32'(bus.fpu_rd), 32'd4);
      tick();
      chk("drain_rd2", 32'(bus.fpu_rd), 32'd10);
      chk("drain_op2", 32'(bus.fpu_op), 32'd5);
      tick();
      chk("drain_done_valid", 32'(bus.fpu_valid), 32'd0);
      chk("drain_inflight_empty", 32'(bus.fpu_q_empty), 32'd0);
      bus.fpu_ready = 1'b0;
      wb(5'd1); wb(5'd2); wb(5'd3); wb(5'd4); wb(5'd10);
      chk("fill_wb_empty", 32'(bus.fpu_q_empty), 32'd1);

      // RAW: consumer of rd=5 waits until the cycle after writeback
      send(4'd1, 3'd0, 5'd20, 5'd21, 5'd22, 5'd5);
      tick();
      send(4'd2, 3'd0, 5'd5, 5'd21, 5'd22, 5'd11);
      settle();
      chk("raw_queued_stall", 32'(bus.dec_fpu_stall), 32'd1);
      bus.fpu_ready = 1'b1;
      tick();
      bus.fpu_ready = 1'b0;
      settle();
      chk("raw_inflight_stall", 32'(bus.dec_fpu_stall), 32'd1);
      bus.fpu_wb_valid = 1'b1;
      bus.fpu_wb_rd    = 5'd5;
      settle();
      chk("raw_wb_same_cycle_stall", 32'(bus.dec_fpu_stall), 32'd1);
      tick();
      bus.fpu_wb_valid = 1'b0;
      settle();
      chk("raw_after_wb_stall", 32'(bus.dec_fpu_stall), 32'd0);
      tick();
      bus.dec_fpu_valid = 1'b0;
      settle();
      chk("raw_head_valid", 32'(bus.fpu_valid), 32'd1);
      chk("raw_head_rd", 32'(bus.fpu_rd), 32'd11);
      bus.fpu_ready = 1'b1;
      tick();
      bus.fpu_ready = 1'b0;
      wb(5'd11);
      chk("raw_empty", 32'(bus.fpu_q_empty), 32'd1);

      // Wrap: ten back-to-back ops with FPU always ready
      bus.fpu_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send(4'(i), 3'd1, 5'd25, 5'd26, 5'd27, 5'(12 + i));
         settle();
         chk("wrap_stall", 32'(bus.dec_fpu_stall), 32'd0);
`ifdef FPU_ISSUE_BYPASS_EN
         chk("wrap_valid", 32'(bus.fpu_valid), 32'd1);
         chk("wrap_rd", 32'(bus.fpu_rd), 32'(12 + i));
`else
         if (i > 0) begin
            chk("wrap_valid", 32'(bus.fpu_valid), 32'd1);
            chk("wrap_rd", 32'(bus.fpu_rd), 32'(11 + i));
            chk("wrap_op", 32'(bus.fpu_op), 32'(i - 1));
         end else begin
            chk("wrap_first_valid", 32'(bus.fpu_valid), 32'd0);
         end
`endif
         tick();
      end
      bus.dec_fpu_valid = 1'b0;
      settle();
`ifndef FPU_ISSUE_BYPASS_EN
      chk("wrap_last_rd", 32'(bus.fpu_rd), 32'd21);
      tick();
`endif
      chk("wrap_done_valid", 32'(bus.fpu_valid), 32'd0);
      bus.fpu_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wb(5'(12 + i));
      end
      chk("wrap_empty", 32'(bus.fpu_q_empty), 32'd1);

      // Flush: rd=9 in flight, rd=6,7,8 queued
      send(4'd9, 3'd0, 5'd25, 5'd26, 5'd27, 5'd9);
      tick();
      bus.dec_fpu_valid = 1'b0;
      bus.fpu_ready     = 1'b1;
      tick();
      bus.fpu_ready = 1'b0;
      for (int i = 6; i <= 8; i++) begin
         send(4'(i), 3'd0, 5'd25, 5'd26, 5'd27, 5'(i));
         tick();
      end
      bus.dec_fpu_valid = 1'b0;
      settle();
      chk("flush_pre_rd", 32'(bus.fpu_rd), 32'd6);
      send(4'd1, 3'd0, 5'd25, 5'd26, 5'd27, 5'd12);
      bus.flush = 1'b1;
      settle();
      chk("flush_stall", 32'(bus.dec_fpu_stall), 32'd1);
      tick();
      bus.flush = 1'b0;
      bus.dec_fpu_valid = 1'b0;
      settle();
      chk("flush_valid", 32'(bus.fpu_valid), 32'd0);
      chk("flush_inflight_empty", 32'(bus.fpu_q_empty), 32'd0);
      send(4'd1, 3'd0, 5'd25, 5'd26, 5'd27, 5'd6);
      settle();
      chk("flush_rd6_free", 32'(bus.dec_fpu_stall), 32'd0);
      send(4'd1, 3'd0, 5'd9, 5'd26, 5'd27, 5'd6);
      settle();
      chk("flush_rd9_busy", 32'(bus.dec_fpu_stall), 32'd1);
      bus.dec_fpu_valid = 1'b0;
      wb(5'd9);
      settle();
      chk("flush_wb_empty", 32'(bus.fpu_q_empty), 32'd1);

      // Bypass: empty queue, FPU ready
      bus.fpu_ready = 1'b1;
      send(4'h3, 3'd2, 5'd25, 5'd26, 5'd27, 5'd13);
      settle();
`ifdef FPU_ISSUE_BYPASS_EN
      chk("byp_valid", 32'(bus.fpu_valid), 32'd1);
      chk("byp_op", 32'(bus.fpu_op), 32'd3);
      chk("byp_rnd", 32'(bus.fpu_rnd_mode), 32'd2);
      tick();
      bus.dec_fpu_valid = 1'b0;
      settle();
      chk("byp_no_queue", 32'(bus.fpu_valid), 32'd0);
`else
      chk("nobyp_valid0", 32'(bus.fpu_valid), 32'd0);
      tick();
      bus.dec_fpu_valid = 1'b0;
      settle();
      chk("nobyp_valid1", 32'(bus.fpu_valid), 32'd1);
      chk("nobyp_op", 32'(bus.fpu_op), 32'd3);
      chk("nobyp_rnd", 32'(bus.fpu_rnd_mode), 32'd2);
      tick();
      chk("nobyp_issued", 32'(bus.fpu_valid), 32'd0);
`endif
      chk("byp_inflight_empty", 32'(bus.fpu_q_empty), 32'd0);
      bus.fpu_ready = 1'b0;
      wb(5'd13);
      chk("byp_empty", 32'(bus.fpu_q_empty), 32'd1);

      // Mid-operation asynchronous reset
      send(4'd1, 3'd0, 5'd25, 5'd26, 5'd27, 5'd14);
      tick();
      send(4'd2, 3'd0, 5'd25, 5'd26, 5'd27, 5'd15);
      tick();
      bus.dec_fpu_valid = 1'b0;
      settle();
      chk("arst_pre_valid", 32'(bus.fpu_valid), 32'd1);
      rst_l = 1'b0;
      settle();
      chk("arst_valid", 32'(bus.fpu_valid), 32'd0);
      chk("arst_empty", 32'(bus.fpu_q_empty), 32'd1);
      chk("arst_rd", 32'(bus.fpu_rd), 32'd0);
      tick();
      rst_l = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
